// File: rtl/vga_scan_ctrl.sv
// Raster timing, scaled line-buffer fetch and palette lookup; video and syncs leave through a 2-stage pipeline.
// Optional raster-line interrupt is built only when VIDEO_RASTER_IRQ_EN is defined.
module vga_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_BITS   = 4,
  parameter int PAL_W      = 8,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int VA_W      = $clog2(H_ACTIVE >> SCALE_LOG2)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                hsyn,
  output logic                vsyn,
  output logic                hnl,
  output logic                vblk,
  output logic [9:0]          vcnext,
  output logic [VA_W-1:0]     va,
  input  logic [PIX_BITS-1:0] d,
  output logic [PAL_W-1:0]    video,
  input  logic                pal_we,
  input  logic [PIX_BITS-1:0] pal_a,
  input  logic [PAL_W-1:0]    pal_d,
  output logic [7:0]          fcnt,
  input  logic                irq_we,
  input  logic [9:0]          irq_d,
  input  logic                irq_ack,
  output logic                irq
);

  localparam int HC_W = $clog2(H_TOTAL);
  localparam int VC_W = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] SUB_MASK = VC_W'((1 << SCALE_LOG2) - 1);

  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [VC_W-1:0]  nv;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             h_wrap, v_last;
  logic             active, hs_lvl, vs_lvl;
  logic             act1_q, hs1_q, vs1_q, hs2_q, vs2_q;
  logic [PAL_W-1:0] video_q;
  logic [PAL_W-1:0] pal_q [2**PIX_BITS];

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_last = (vc_q == V_LAST);
    hc_d   = h_wrap ? '0 : hc_q + HC_W'(1);
    nv     = v_last ? '0 : vc_q + VC_W'(1);
    vc_d   = h_wrap ? nv : vc_q;
    fcnt_d = (h_wrap && v_last) ? fcnt_q + 8'd1 : fcnt_q;
    active = (hc_q < H_ACT) && (vc_q < V_ACT);
    hs_lvl = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_lvl = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Fetch the next source line only when it is a new one after vertical replication.
  assign hnl    = (hc_q == H_ACT) && (nv < V_ACT) && ((nv & SUB_MASK) == '0);
  assign vcnext = 10'(nv >> SCALE_LOG2);
  assign va     = VA_W'(hc_q >> SCALE_LOG2);
  assign vblk   = (vc_q >= V_ACT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      fcnt_q <= '0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pal_we) pal_q[pal_a] <= pal_d;
  end

  // Syncs travel through the same two stages as the pixel so their edges line up with video.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act1_q  <= 1'b0;
      hs1_q   <= ~HSYNC_POL;
      vs1_q   <= ~VSYNC_POL;
      hs2_q   <= ~HSYNC_POL;
      vs2_q   <= ~VSYNC_POL;
      video_q <= '0;
    end else begin
      act1_q  <= active;
      hs1_q   <= hs_lvl;
      vs1_q   <= vs_lvl;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      video_q <= act1_q ? pal_q[d] : '0;
    end
  end

  assign hsyn  = hs2_q;
  assign vsyn  = vs2_q;
  assign video = video_q;
  assign fcnt  = fcnt_q;

`ifdef VIDEO_RASTER_IRQ_EN
  logic [9:0] cmp_q;
  logic       irq_flag_q, irq_flag_d;
  logic       irq_hit;

  always_comb begin
    irq_hit    = (hc_q == H_ACT) && (10'(vc_q) == cmp_q);
    irq_flag_d = irq_flag_q;
    if (irq_ack) irq_flag_d = 1'b0;
    if (irq_hit) irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_q      <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      if (irq_we) cmp_q <= irq_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  assign irq = irq_flag_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_we, irq_d, irq_ack};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench on a reduced 24x12 raster (16x8 visible), scale 2 plus a scale-1 twin for fetch checks.
module tb_vga_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] d, d0, pal_a;
  logic       pal_we, irq_we, irq_ack;
  logic [7:0] pal_d;
  logic [9:0] irq_d;

  logic       hsyn, vsyn, hnl, vblk, irq;
  logic [9:0] vcnext;
  logic [2:0] va;
  logic [7:0] video, fcnt;

  logic       hsyn0, vsyn0, hnl0, vblk0, irq0;
  logic [9:0] vcnext0;
  logic [3:0] va0;
  logic [7:0] video0, fcnt0;

  vga_scan_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .SCALE_LOG2(1), .PIX_BITS(4), .PAL_W(8)) u_dut (
    .clk(clk), .reset(reset), .hsyn(hsyn), .vsyn(vsyn), .hnl(hnl), .vblk(vblk),
    .vcnext(vcnext), .va(va), .d(d), .video(video), .pal_we(pal_we), .pal_a(pal_a),
    .pal_d(pal_d), .fcnt(fcnt), .irq_we(irq_we), .irq_d(irq_d), .irq_ack(irq_ack), .irq(irq));

  vga_scan_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                  .SCALE_LOG2(0), .PIX_BITS(4), .PAL_W(8)) u_s0 (
    .clk(clk), .reset(reset), .hsyn(hsyn0), .vsyn(vsyn0), .hnl(hnl0), .vblk(vblk0),
    .vcnext(vcnext0), .va(va0), .d(d0), .video(video0), .pal_we(pal_we), .pal_a(pal_a),
    .pal_d(pal_d), .fcnt(fcnt0), .irq_we(irq_we), .irq_d(irq_d), .irq_ack(irq_ack), .irq(irq0));

  // Raster position model and a line buffer holding index 5 for source pixels 0..1, index 3 elsewhere.
  int mh, mv;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mh <= 0;
      mv <= 0;
    end else if (mh == 23) begin
      mh <= 0;
      mv <= (mv == 11) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  always @(posedge clk) d <= (va < 3'd2) ? 4'd5 : 4'd3;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_to(input int h, input int v);
    for (int i = 0; i < 400; i++) begin
      if (mh == h && mv == v) break;
      step();
    end
    chk("goto_position", {16'(mh), 16'(mv)}, {16'(h), 16'(v)});
  endtask

  initial begin
    int hs_low, vs_low, hs_bad, vs_bad, vid_bad, va_bad, vblk_bad, hnl_bad, hnl_cnt, irq_bad;
    int p, ph, pv, f_h, f_v, f0_h, f0_v;
    logic [9:0] f_vcn, f0_vcn;
    logic [7:0] exp_vid;
    logic exp_hs, exp_vs, exp_hnl;
    logic [9:0] vcn_seen[$];
    logic [9:0] vcn_exp[8];

    hs_low = 0; vs_low = 0; hs_bad = 0; vs_bad = 0; vid_bad = 0; va_bad = 0;
    vblk_bad = 0; hnl_bad = 0; hnl_cnt = 0; irq_bad = 0;
    vcn_exp = '{10'd1, 10'd2, 10'd3, 10'd0, 10'd1, 10'd2, 10'd3, 10'd0};
    d0 = 4'd0; pal_we = 1'b0; pal_a = '0; pal_d = '0;
    irq_we = 1'b0; irq_d = '0; irq_ack = 1'b0;

    step();
    chk("rst_hsyn", hsyn, 1);
    chk("rst_vsyn", vsyn, 1);
    chk("rst_video", video, 0);
    chk("rst_fcnt", fcnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_hnl", hnl, 0);
    chk("rst_vblk", vblk, 0);
    chk("rst_va", va, 0);
    chk("rst_vcnext_s1", vcnext, 0);
    chk("rst_vcnext_s0", vcnext0, 1);

    pal_we = 1'b1; pal_a = 4'd5; pal_d = 8'h3C;
    step();
    pal_a = 4'd3; pal_d = 8'hA5;
    step();
    pal_we = 1'b0;
    reset = 1'b1;

    for (int n = 1; n <= 576; n++) begin
      step();
      if (n >= 2) begin
        p = n - 2; ph = p % 24; pv = (p / 24) % 12;
        exp_hs = !(ph >= 18 && ph <= 20);
        exp_vs = !(pv == 9 || pv == 10);
        exp_vid = (ph < 16 && pv < 8) ? ((ph < 4) ? 8'h3C : 8'hA5) : 8'h00;
      end else begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_vid = 8'h00;
      end
      if (hsyn == 1'b0) hs_low++;
      if (vsyn == 1'b0) vs_low++;
      if (hsyn !== exp_hs) hs_bad++;
      if (vsyn !== exp_vs) vs_bad++;
      if (video !== exp_vid) vid_bad++;
      if (mh < 16 && va !== 3'(mh / 2)) va_bad++;
      if (vblk !== (mv >= 8)) vblk_bad++;
      if (irq !== 1'b0) irq_bad++;
      exp_hnl = (mh == 16) && (mv == 1 || mv == 3 || mv == 5 || mv == 11);
      if (hnl !== exp_hnl) hnl_bad++;
      if (hnl === 1'b1) begin
        hnl_cnt++;
        vcn_seen.push_back(vcnext);
      end
      if (n == 1) chk("video_first_blank", video, 8'h00);
      if (n == 2) chk("video_pixel0", video, 8'h3C);
      if (n == 6) chk("video_pixel4", video, 8'hA5);
      if (n == 15) chk("va_last_active", va, 3'd7);
      if (n == 288) chk("fcnt_frame1", fcnt, 1);
    end
    chk("fcnt_frame2", fcnt, 2);
    chk("hsyn_low_cycles", hs_low, 72);
    chk("vsyn_low_cycles", vs_low, 96);
    chk("hsyn_alignment", hs_bad, 0);
    chk("vsyn_alignment", vs_bad, 0);
    chk("video_per_pixel", vid_bad, 0);
    chk("va_scaled", va_bad, 0);
    chk("vblk_region", vblk_bad, 0);
    chk("hnl_placement", hnl_bad, 0);
    chk("hnl_count", hnl_cnt, 8);
    for (int i = 0; i < 8; i++)
      chk("vcnext_seq", (i < vcn_seen.size()) ? vcn_seen[i] : 10'h3FF, vcn_exp[i]);

    step();
    step();
    chk("pal_before_write", video, 8'h3C);
    step();
    pal_we = 1'b1; pal_a = 4'd5; pal_d = 8'hC3;
    step();
    pal_we = 1'b0;
    chk("pal_write_old", video, 8'h3C);
    step();
    chk("pal_write_new", video, 8'hC3);

`ifdef VIDEO_RASTER_IRQ_EN
    irq_we = 1'b1; irq_d = 10'd3; irq_ack = 1'b1;
    step();
    irq_we = 1'b0; irq_ack = 1'b0;
    chk("irq_cleared", irq, 0);
    go_to(16, 3);
    chk("irq_before_set", irq, 0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_set_beats_ack", irq, 1);
    step();
    chk("irq_sticky", irq, 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("irq_ack_clears", irq, 0);
`else
    chk("irq_tied_low", irq_bad, 0);
    irq_we = 1'b1; irq_d = 10'd3; irq_ack = 1'b0;
    step();
    irq_we = 1'b0;
    go_to(17, 3);
    chk("irq_disabled", irq, 0);
`endif

    go_to(20, 9);
    chk("pre_reset_hsyn", hsyn, 0);
    chk("pre_reset_vsyn", vsyn, 0);
    reset = 1'b0;
    #1;
    chk("reset_hsyn_now", hsyn, 1);
    chk("reset_vsyn_now", vsyn, 1);
    chk("reset_video_now", video, 0);
    chk("reset_va_now", va, 0);
    chk("reset_vblk_now", vblk, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_fcnt", fcnt, 0);
    chk("reset_irq", irq, 0);
    chk("reset_hsyn_held", hsyn, 1);
    reset = 1'b1;

    f_h = -1; f_v = -1; f0_h = -1; f0_v = -1; f_vcn = '1; f0_vcn = '1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (hnl0 === 1'b1 && f0_h < 0) begin f0_h = mh; f0_v = mv; f0_vcn = vcnext0; end
      if (hnl === 1'b1 && f_h < 0) begin f_h = mh; f_v = mv; f_vcn = vcnext; end
    end
    chk("s0_first_hnl_pos", {16'(f0_h), 16'(f0_v)}, {16'd16, 16'd0});
    chk("s0_first_vcnext", f0_vcn, 1);
    chk("s1_first_hnl_pos", {16'(f_h), 16'(f_v)}, {16'd16, 16'd1});
    chk("s1_first_vcnext", f_vcn, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
